// File: rtl/cim_job_sequencer.sv
// cim_job_sequencer: orders ACT/WM/WS loads onto the single CiM input port,
// waits for the result handshake, repeats for num_jobs_i jobs (busy/phase/idx/done).
module cim_job_sequencer #(
  parameter int DATA_W    = 32,
  parameter int ACT_BEATS = 12,
  parameter int WM_BEATS  = 128,
  parameter int WS_BEATS  = 32,
  parameter int JOB_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [JOB_W-1:0]  num_jobs_i,
  input  logic              abort_i,
  input  logic              act_valid_i,
  input  logic [DATA_W-1:0] act_data_i,
  output logic              act_ready_o,
  input  logic              wm_valid_i,
  input  logic [DATA_W-1:0] wm_data_i,
  output logic              wm_ready_o,
  input  logic              ws_valid_i,
  input  logic [DATA_W-1:0] ws_data_i,
  output logic              ws_ready_o,
  output logic              acc_valid_o,
  output logic [DATA_W-1:0] acc_data_o,
  input  logic              acc_ready_i,
  input  logic              res_valid_i,
  input  logic              res_ready_i,
  output logic              busy_o,
  output logic [2:0]        phase_o,
  output logic [JOB_W-1:0]  job_idx_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_ACT = 3'd1,
    LD_WM  = 3'd2,
    LD_WS  = 3'd3,
    RUN    = 3'd4
  } state_e;

  localparam int MAX_AW = (ACT_BEATS > WM_BEATS) ? ACT_BEATS : WM_BEATS;
  localparam int MAX_B  = (MAX_AW > WS_BEATS) ? MAX_AW : WS_BEATS;
  localparam int CNT_W  = (MAX_B > 1) ? $clog2(MAX_B) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic [JOB_W-1:0]   job_q, job_d;
  logic [JOB_W-1:0]   nj_q, nj_d;
  logic               done_q, done_d;

  logic               beat;
  logic               res_hs;
  logic               last_job;
  logic [CNT_W-1:0]   last_beat;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      job_q   <= '0;
      nj_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      job_q   <= job_d;
      nj_q    <= nj_d;
      done_q  <= done_d;
    end
  end

  // Zero-latency mux: the selected requester sees the
  // accelerator ready directly, everyone else sees 0.
  always_comb begin
    acc_valid_o = 1'b0;
    acc_data_o  = '0;
    act_ready_o = 1'b0;
    wm_ready_o  = 1'b0;
    ws_ready_o  = 1'b0;
    last_beat   = '0;
    unique case (state_q)
      LD_ACT: begin
        acc_valid_o = act_valid_i;
        acc_data_o  = act_data_i;
        act_ready_o = acc_ready_i;
        last_beat   = CNT_W'(ACT_BEATS - 1);
      end
      LD_WM: begin
        acc_valid_o = wm_valid_i;
        acc_data_o  = wm_data_i;
        wm_ready_o  = acc_ready_i;
        last_beat   = CNT_W'(WM_BEATS - 1);
      end
      LD_WS: begin
        acc_valid_o = ws_valid_i;
        acc_data_o  = ws_data_i;
        ws_ready_o  = acc_ready_i;
        last_beat   = CNT_W'(WS_BEATS - 1);
      end
      default: ;
    endcase
  end

  assign beat     = acc_valid_o && acc_ready_i;
  assign res_hs   = res_valid_i && res_ready_i;
  assign last_job = (job_q == nj_q - JOB_W'(1));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    job_d   = job_q;
    nj_d    = nj_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start_i && (num_jobs_i != '0)) begin
        state_d = LD_ACT;
        nj_d    = num_jobs_i;
        job_d   = '0;
        beat_d  = '0;
      end
    end else if (abort_i) begin
      state_d = IDLE;
      beat_d  = '0;
      job_d   = '0;
    end else begin
      unique case (state_q)
        LD_ACT, LD_WM, LD_WS: begin
          if (beat) begin
            if (beat_q == last_beat) begin
              beat_d = '0;
              unique case (state_q)
                LD_ACT:  state_d = LD_WM;
                LD_WM:   state_d = LD_WS;
                default: state_d = RUN;
              endcase
            end else begin
              beat_d = beat_q + CNT_W'(1);
            end
          end
        end
        RUN: begin
          if (res_hs) begin
            if (last_job) begin
              state_d = IDLE;
              job_d   = '0;
              done_d  = 1'b1;
            end else begin
              state_d = LD_ACT;
              job_d   = job_q + JOB_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign phase_o   = state_q;
  assign job_idx_o = job_q;
  assign done_o    = done_q;

endmodule
